// File: rtl/vector_logic_sequencer_if.sv
// -----------------------------------------------------------------------------
// vector_logic_sequencer_pkg / vector_logic_sequencer_if
//
// Purpose:
//   Shared operation encoding and the issue/writeback bus of the vector logic
//   sequencer.
//
// Package:
//   logic_mode_t  2-bit operation select. 2'b00 is deliberately unused, so an
//                 unset or corrupted mode yields an all-zero result.
//
// Interface signals (VLEN = vector register width):
//   req_valid       issue -> seq   an operation is presented
//   req_ready       seq -> issue   sequencer can accept an operation
//   req_logic_mode  issue -> seq   AND / OR / XOR select
//   req_vs2         issue -> seq   operand vs2, VLEN bits
//   req_vs1         issue -> seq   operand vs1, VLEN bits
//   resp_valid      seq -> wb      assembled result available
//   resp_ready      wb -> seq      writeback accepts the result
//   resp_vd         seq -> wb      assembled result, VLEN bits
//
// Modports:
//   master  issue stage / writeback side (testbench)
//   slave   the sequencer
// -----------------------------------------------------------------------------
package vector_logic_sequencer_pkg;

    typedef enum logic [1:0] {
        ENABLED_AND_MODE = 2'b01,
        ENABLED_OR_MODE  = 2'b10,
        ENABLED_XOR_MODE = 2'b11
    } logic_mode_t;

endpackage

interface vector_logic_sequencer_if #(
    parameter int VLEN = 128
);
    import vector_logic_sequencer_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic_mode_t       req_logic_mode;
    logic [VLEN-1:0]   req_vs2;
    logic [VLEN-1:0]   req_vs1;
    logic              resp_valid;
    logic              resp_ready;
    logic [VLEN-1:0]   resp_vd;

    modport master (
        output req_valid, req_logic_mode, req_vs2, req_vs1, resp_ready,
        input  req_ready, resp_valid, resp_vd
    );

    modport slave (
        input  req_valid, req_logic_mode, req_vs2, req_vs1, resp_ready,
        output req_ready, resp_valid, resp_vd
    );

endinterface

// File: rtl/vector_logic_sequencer.sv
// -----------------------------------------------------------------------------
// vector_logic_sequencer
//
// Purpose:
//   Multi-beat controller that applies a VLEN-wide AND/OR/XOR through a narrow
//   LANE_WIDTH slice datapath, one slice per clock, and assembles the full
//   result. Trades BEATS cycles of latency for a datapath LANE_WIDTH wide.
//
// Parameters:
//   VLEN        vector width in bits (must match the bus interface VLEN)
//   LANE_WIDTH  bits processed per beat; VLEN must be a multiple of it
//
// Ports:
//   clock    in   single clock, all state on rising edge
//   reset_n  in   asynchronous active-low reset
//   flush    in   synchronous abort; wins over every other event
//   bus      slave modport of vector_logic_sequencer_if (request/response)
//   busy     out  high while an operation is in flight or awaiting writeback
//
// Timing:
//   Accept at edge T -> resp_valid high after edge T+BEATS. With resp_ready
//   held high, consecutive accepts are BEATS+2 edges apart. All outputs come
//   from state decode or registers; req_ready is additionally gated by flush.
// -----------------------------------------------------------------------------
module vector_logic_sequencer
    import vector_logic_sequencer_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush,
    vector_logic_sequencer_if.slave   bus,
    output logic                      busy
);

    localparam int BEATS  = VLEN / LANE_WIDTH;
    // A single-beat configuration still needs a one-bit counter to exist.
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if ((VLEN % LANE_WIDTH) != 0 || LANE_WIDTH <= 0) begin : g_bad_cfg
            $error("vector_logic_sequencer: VLEN must be a positive multiple of LANE_WIDTH");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [1:0]            state_q;
    logic [BEAT_W-1:0]     beat_q;
    logic_mode_t           mode_q;
    logic [VLEN-1:0]       vs2_q;
    logic [VLEN-1:0]       vs1_q;
    logic [VLEN-1:0]       result_q;

    logic [LANE_WIDTH-1:0] slice_vs2;
    logic [LANE_WIDTH-1:0] slice_vs1;
    logic [LANE_WIDTH-1:0] slice_res;
    int                    lane_base;

    // Slice datapath: the only logic that scales with LANE_WIDTH.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; an unassigned path would infer a latch.
        lane_base = int'(beat_q) * LANE_WIDTH;
        slice_vs2 = vs2_q[lane_base +: LANE_WIDTH];
        slice_vs1 = vs1_q[lane_base +: LANE_WIDTH];
        slice_res = '0;
        case (mode_q)
            ENABLED_AND_MODE: slice_res = slice_vs2 & slice_vs1;
            ENABLED_OR_MODE:  slice_res = slice_vs2 | slice_vs1;
            ENABLED_XOR_MODE: slice_res = slice_vs2 ^ slice_vs1;
            default:          slice_res = '0;
        endcase
    end

    // Flush blocks acceptance in the same cycle, so req_ready must see it.
    assign bus.req_ready  = (state_q == ST_IDLE) && !flush;
    assign bus.resp_valid = (state_q == ST_DONE);
    assign bus.resp_vd    = result_q;
    assign busy           = (state_q != ST_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            // NOTE: the wide operand/result registers are reset too, so an
            // aborted operation never leaves stale data visible on resp_vd.
            mode_q   <= logic_mode_t'(2'b00);
            vs2_q    <= '0;
            vs1_q    <= '0;
            result_q <= '0;
        end else if (flush) begin
            // The partial result is left in place; it is never presented
            // because resp_valid is decoded from state.
            state_q <= ST_IDLE;
            beat_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        mode_q   <= bus.req_logic_mode;
                        vs2_q    <= bus.req_vs2;
                        vs1_q    <= bus.req_vs1;
                        result_q <= '0;
                        beat_q   <= '0;
                        state_q  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    result_q[lane_base +: LANE_WIDTH] <= slice_res;
                    if (beat_q == LAST_BEAT) begin
                        beat_q  <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.resp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    beat_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_logic_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vector_logic_sequencer
//
// Directed bench for vector_logic_sequencer at VLEN=128, LANE_WIDTH=32
// (BEATS=4). Inputs change 1 ns after a rising edge; outputs are sampled at
// that same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_vector_logic_sequencer;
    import vector_logic_sequencer_pkg::*;

    localparam int VLEN       = 128;
    localparam int LANE_WIDTH = 32;
    localparam int BEATS      = VLEN / LANE_WIDTH;
    localparam int RESP_BOUND = 20;

    logic clock;
    logic reset_n;
    logic flush;
    logic busy;

    int n_asserts;
    int n_fail;
    int cyc;
    int last_accept;

    vector_logic_sequencer_if #(.VLEN(VLEN)) bus ();

    vector_logic_sequencer #(
        .VLEN       (VLEN),
        .LANE_WIDTH (LANE_WIDTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus.slave),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Rising-edge count, used to measure latency and accept spacing.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [VLEN-1:0] observed,
                         input logic [VLEN-1:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present an operation, wait (bounded) for req_ready, let the edge accept it.
    task automatic issue(input logic_mode_t mode, input logic [VLEN-1:0] vs2,
                         input logic [VLEN-1:0] vs1);
        int waited;
        bus.req_valid      = 1'b1;
        bus.req_logic_mode = mode;
        bus.req_vs2        = vs2;
        bus.req_vs1        = vs1;
        #1;
        waited = 0;
        while (!bus.req_ready && waited < RESP_BOUND) begin
            step();
            waited++;
        end
        check("req_ready_timeout", bus.req_ready, 1'b1);
        step();
        last_accept   = cyc;
        bus.req_valid = 1'b0;
    endtask

    // Wait (bounded) for resp_valid, then check latency and data.
    task automatic expect_resp(input string tag, input logic [VLEN-1:0] expected);
        int waited;
        waited = 0;
        while (!bus.resp_valid && waited < RESP_BOUND) begin
            step();
            waited++;
        end
        check({tag, "_resp_valid"}, bus.resp_valid, 1'b1);
        check({tag, "_latency"}, VLEN'(cyc - last_accept), VLEN'(BEATS));
        check({tag, "_resp_vd"}, bus.resp_vd, expected);
    endtask

    initial begin
        int acc_first;
        logic [VLEN-1:0] held_vd;

        n_asserts          = 0;
        n_fail             = 0;
        cyc                = 0;
        last_accept        = 0;
        reset_n            = 1'b0;
        flush              = 1'b0;
        bus.req_valid      = 1'b0;
        bus.req_logic_mode = ENABLED_AND_MODE;
        bus.req_vs2        = '0;
        bus.req_vs1        = '0;
        bus.resp_ready     = 1'b0;

        // ---------------- reset state ----------------
        #2;
        check("rst_req_ready",  bus.req_ready,  1'b1);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_vd",    bus.resp_vd,    '0);
        check("rst_busy",       busy,           1'b0);
        step();
        step();
        reset_n = 1'b1;

        // ---------------- AND, latency 4 ----------------
        issue(ENABLED_AND_MODE, 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000,
                                128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F);
        check("and_busy",      busy,          1'b1);
        check("and_req_ready", bus.req_ready, 1'b0);
        step();
        step();
        step();
        check("and_no_early_resp", bus.resp_valid, 1'b0);
        expect_resp("and", 128'h0F0F0000_0F0F0000_0F0F0000_0F0F0000);
        check("and_done_req_ready", bus.req_ready, 1'b0);
        bus.resp_ready = 1'b1;
        step();
        check("and_idle_busy",       busy,           1'b0);
        check("and_idle_resp_valid", bus.resp_valid, 1'b0);
        check("and_idle_req_ready",  bus.req_ready,  1'b1);

        // ---------------- OR / XOR / AND / illegal, back-to-back ----------------
        issue(ENABLED_OR_MODE, {4{32'hAAAAAAAA}}, {4{32'h55555555}});
        acc_first = last_accept;
        expect_resp("or", {VLEN{1'b1}});
        issue(ENABLED_XOR_MODE, {4{32'hAAAAAAAA}}, {4{32'h55555555}});
        check("b2b_spacing", VLEN'(last_accept - acc_first), VLEN'(BEATS + 2));
        expect_resp("xor", {VLEN{1'b1}});
        issue(ENABLED_AND_MODE, {4{32'hAAAAAAAA}}, {4{32'h55555555}});
        expect_resp("and_zero", '0);
        issue(logic_mode_t'(2'b00), {VLEN{1'b1}}, {VLEN{1'b1}});
        expect_resp("illegal", '0);
        step();

        // ---------------- back-pressure ----------------
        bus.resp_ready = 1'b0;
        issue(ENABLED_XOR_MODE, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                                128'hFFFFFFFF_00000000_FFFFFFFF_00000000);
        expect_resp("bp", 128'hFEDCBA98_89ABCDEF_01234567_76543210);
        held_vd = 128'hFEDCBA98_89ABCDEF_01234567_76543210;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.req_vs1 = ~bus.req_vs1;
            step();
            check("bp_resp_valid", bus.resp_valid, 1'b1);
            check("bp_resp_vd",    bus.resp_vd,    held_vd);
            check("bp_req_ready",  bus.req_ready,  1'b0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        step();
        check("bp_release_busy", busy, 1'b0);

        // ---------------- flush at beat 2 ----------------
        issue(ENABLED_AND_MODE, {VLEN{1'b1}}, {VLEN{1'b1}});
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("flush_busy",       busy,           1'b0);
        check("flush_req_ready",  bus.req_ready,  1'b1);
        check("flush_resp_valid", bus.resp_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_no_resp", bus.resp_valid, 1'b0);
        end
        issue(ENABLED_XOR_MODE, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0,
                                128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF);
        expect_resp("post_flush", 128'hDEAD4110_CAFE0FF2_1234A987_9ABC210F);
        step();

        // ---------------- asynchronous reset mid-BUSY ----------------
        issue(ENABLED_OR_MODE, 128'h1, 128'h2);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy",       busy,           1'b0);
        check("arst_req_ready",  bus.req_ready,  1'b1);
        check("arst_resp_valid", bus.resp_valid, 1'b0);
        check("arst_resp_vd",    bus.resp_vd,    '0);
        step();
        reset_n = 1'b1;
        step();
        check("arst_stays_idle", busy, 1'b0);
        issue(ENABLED_AND_MODE, 128'h00000000_11111111_22222222_33333333, {VLEN{1'b1}});
        expect_resp("post_arst", 128'h00000000_11111111_22222222_33333333);
        step();

        // ---------------- flush with req_valid in IDLE ----------------
        flush              = 1'b1;
        bus.req_valid      = 1'b1;
        bus.req_logic_mode = ENABLED_OR_MODE;
        bus.req_vs2        = 128'hF0000000_00000000_00000000_0000000F;
        bus.req_vs1        = 128'h0F000000_00000000_00000000_000000F0;
        #1;
        check("fidle_req_ready", bus.req_ready, 1'b0);
        step();
        flush = 1'b0;
        #1;
        check("fidle_not_accepted", busy,          1'b0);
        check("fidle_req_ready_on", bus.req_ready, 1'b1);
        step();
        last_accept   = cyc;
        bus.req_valid = 1'b0;
        check("fidle_accepted", busy, 1'b1);
        expect_resp("fidle", 128'hFF000000_00000000_00000000_000000FF);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
